// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline stage with a two-entry skid buffer, synchronous flush
// and optional stall/bubble counters (enabled by defining PIPE_STAGE_PERF_EN).
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int unsigned OCC_W = 2;

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              in_ready_q,   in_ready_d;
    logic [OCC_W-1:0]  occupancy_q,  occupancy_d;

    logic push;
    logic pop;

    assign push = in_valid & in_ready_q;
    assign pop  = main_valid_q & out_ready;

    // Next-state for the main/skid entries; flush wins over both handshakes.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = '0;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
        end else if (!main_valid_q) begin
            if (push) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end
        end else if (!skid_valid_q) begin
            if (push && pop) begin
                main_data_d = in_data;
            end else if (push) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end else if (pop) begin
                main_valid_d = 1'b0;
                main_data_d  = '0;
            end
        end else if (pop) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
        end

        in_ready_d  = ~skid_valid_d;
        occupancy_d = OCC_W'(main_valid_d) + OCC_W'(skid_valid_d);
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
            occupancy_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
            occupancy_q  <= occupancy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign occupancy = occupancy_q;

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating counters judged on the outputs presented before the edge.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (main_valid_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (!main_valid_q && out_ready && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model plus directed literal checks.
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W = 16;
`ifdef PIPE_STAGE_PERF_EN
    localparam int unsigned CNT_W = 2;
`else
    localparam int unsigned CNT_W = 32;
`endif
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    logic              CLK;
    logic              nRST;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush      (flush),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cmp(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: the stage is a FIFO of depth two; accepting means fewer than two held.
    logic [DATA_W-1:0] mq[$];
    longint m_stall  = 0;
    longint m_bubble = 0;
    bit     model_ok = 0;

    always @(posedge CLK) begin
        bit exp_valid;
        bit do_push;
        bit do_pop;
        exp_valid = (mq.size() > 0);
        if (!nRST) begin
            mq.delete();
            m_stall  = 0;
            m_bubble = 0;
            model_ok = 1;
        end else begin
            if (exp_valid && !out_ready && m_stall < CNT_MAX) m_stall++;
            if (!exp_valid && out_ready && m_bubble < CNT_MAX) m_bubble++;
            if (flush) begin
                mq.delete();
            end else begin
                do_push = in_valid && (mq.size() < 2);
                do_pop  = exp_valid && out_ready;
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back(in_data);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (model_ok) begin
            cmp("out_valid", longint'(out_valid), longint'(mq.size() > 0));
            cmp("out_data", longint'(out_data), (mq.size() > 0) ? longint'(mq[0]) : 0);
            cmp("in_ready", longint'(in_ready), longint'(mq.size() < 2));
            cmp("occupancy", longint'(occupancy), longint'(mq.size()));
`ifdef PIPE_STAGE_PERF_EN
            cmp("stall_cnt", longint'(stall_cnt), m_stall);
            cmp("bubble_cnt", longint'(bubble_cnt), m_bubble);
`else
            cmp("stall_cnt", longint'(stall_cnt), 0);
            cmp("bubble_cnt", longint'(bubble_cnt), 0);
`endif
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic lit(input string name, input bit v, input int d, input bit r, input int occ);
        cmp({name, ".out_valid"}, longint'(out_valid), longint'(v));
        cmp({name, ".out_data"}, longint'(out_data), longint'(d));
        cmp({name, ".in_ready"}, longint'(in_ready), longint'(r));
        cmp({name, ".occupancy"}, longint'(occupancy), longint'(occ));
    endtask

    task automatic push_drive(input bit v, input int d, input bit r);
        in_valid  = v;
        in_data   = DATA_W'(d);
        out_ready = r;
    endtask

    initial begin
        nRST = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        step(); step();
        nRST = 1'b1;
        lit("reset", 0, 0, 1, 0);
        cmp("reset.stall_cnt", longint'(stall_cnt), 0);
        cmp("reset.bubble_cnt", longint'(bubble_cnt), 0);

        // Streaming at full rate.
        for (int i = 1; i <= 4; i++) begin
            push_drive(1, i, 1);
            step();
            lit("stream", 1, i, 1, 1);
        end
        push_drive(0, 0, 1);
        step();
        lit("stream_drain", 0, 0, 1, 0);

        // Backpressure into the skid entry.
        push_drive(1, 'hA, 0); step(); lit("bp_a", 1, 'hA, 1, 1);
        push_drive(1, 'hB, 0); step(); lit("bp_b", 1, 'hA, 0, 2);
        push_drive(1, 'hC, 0); step(); lit("bp_c_held", 1, 'hA, 0, 2);
        push_drive(1, 'hC, 1); step(); lit("bp_pop_a", 1, 'hB, 1, 1);
        push_drive(1, 'hC, 1); step(); lit("bp_pop_b", 1, 'hC, 1, 1);
        push_drive(0, 0, 1);   step(); lit("bp_pop_c", 0, 0, 1, 0);

        // Flush in TWO with a presented push, then flush in ONE with an accepted push.
        push_drive(1, 'h11, 0); step();
        push_drive(1, 'h12, 0); step(); lit("fl_two", 1, 'h11, 0, 2);
        push_drive(1, 'hD, 0); flush = 1'b1; step(); flush = 1'b0;
        lit("fl_two_after", 0, 0, 1, 0);
        push_drive(1, 'h21, 0); step(); lit("fl_one", 1, 'h21, 1, 1);
        push_drive(1, 'hD, 1); flush = 1'b1; step(); flush = 1'b0;
        lit("fl_one_after", 0, 0, 1, 0);
        push_drive(0, 0, 1); step(); lit("fl_no_d", 0, 0, 1, 0);

        // Reset while holding two payloads.
        push_drive(1, 'h31, 0); step();
        push_drive(1, 'h32, 0); step(); lit("rst_two", 1, 'h31, 0, 2);
        push_drive(0, 0, 0); nRST = 1'b0; step(); nRST = 1'b1;
        lit("rst_mid", 0, 0, 1, 0);
        cmp("rst_mid.stall_cnt", longint'(stall_cnt), 0);
        push_drive(1, 'h5A, 1); step(); lit("rst_first", 1, 'h5A, 1, 1);
        push_drive(0, 0, 0); step(); lit("rst_hold", 1, 'h5A, 1, 1);

`ifdef PIPE_STAGE_PERF_EN
        // Stall counter saturation; one stall cycle already counted by rst_hold.
        for (int i = 0; i < 4; i++) step();
        cmp("perf_sat", longint'(stall_cnt), 3);
        flush = 1'b1; step(); flush = 1'b0;
        cmp("perf_flush_keep", longint'(stall_cnt), 3);
        nRST = 1'b0; step(); nRST = 1'b1;
        cmp("perf_reset_clear", longint'(stall_cnt), 0);
`endif

        // Randomised traffic against the model, with rare flush and reset.
        for (int i = 0; i < 10000; i++) begin
            if (!(in_valid && !in_ready)) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = DATA_W'($urandom);
            end
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 99) == 0);
            nRST      = ($urandom_range(0, 499) != 0);
            step();
        end
        nRST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(); step();
        lit("final_drain", 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
